// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the iterative multiply/divide sequencer: opcode encodings
// and FSM state encoding.
package muldiv_seq_pkg;

  localparam int unsigned MD_OP_WIDTH = 3;

  localparam logic [MD_OP_WIDTH-1:0] MD_NONE  = 3'd0;
  localparam logic [MD_OP_WIDTH-1:0] MD_MULTU = 3'd1;
  localparam logic [MD_OP_WIDTH-1:0] MD_DIVU  = 3'd2;
  localparam logic [MD_OP_WIDTH-1:0] MD_MULT  = 3'd3;
  localparam logic [MD_OP_WIDTH-1:0] MD_DIV   = 3'd4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_iter_core.sv
// One bit-step of the multiply/divide datapath, purely combinational.
// Accumulator layout is 2*WIDTH+1 bits:
//   multiply: {carry/upper partial product (WIDTH+1), remaining multiplier bits (WIDTH)}
//   divide:   {partial remainder (WIDTH+1), dividend shifting out / quotient shifting in (WIDTH)}
module muldiv_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc_in,
  input  logic [WIDTH-1:0] operand,
  input  logic             is_div,
  output logic [2*WIDTH:0] acc_out
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] sh;
  logic [WIDTH:0]   diff;
  logic             fits;

  // Shift-add for multiply, restoring subtract for divide.
  always_comb begin
    acc_out = acc_in;
    sum     = '0;
    sh      = '0;
    diff    = '0;
    fits    = 1'b0;
    if (is_div) begin
      sh      = {acc_in[2*WIDTH-1:0], 1'b0};
      diff    = sh[2*WIDTH:WIDTH] - {1'b0, operand};
      fits    = sh[2*WIDTH:WIDTH] >= {1'b0, operand};
      acc_out = fits ? {diff, sh[WIDTH-1:1], 1'b1} : sh;
    end else begin
      // Upper half never carries past bit WIDTH, so acc_in[2*WIDTH] is zero here.
      sum     = acc_in[2*WIDTH:WIDTH] + (acc_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      acc_out = {1'b0, sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer beside the EX stage. Stalls the front of the
// pipeline while it runs one bit-step per cycle, then commits into HI/LO.
// Optional build macro: MULDIV_SIGNED_EN makes MD_MULT/MD_DIV signed; otherwise
// they behave as MD_MULTU/MD_DIVU.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   start,
  input  logic [MD_OP_WIDTH-1:0] op,
  input  logic [WIDTH-1:0]       opa,
  input  logic [WIDTH-1:0]       opb,
  input  logic                   hi_we,
  input  logic                   lo_we,
  input  logic [WIDTH-1:0]       wdata,
  output logic                   stall,
  output logic                   busy,
  output logic                   done,
  output logic                   div_by_zero,
  output logic [WIDTH-1:0]       hi,
  output logic [WIDTH-1:0]       lo
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2*WIDTH:0] acc_q, acc_next;
  logic [WIDTH-1:0] operand_q;
  logic             is_div_q, neg_res_q, neg_a_q, div_zero_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             dbz_q;

  logic             accept, last;
  logic             is_signed, req_div, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem, hi_res, lo_res;

`ifdef MULDIV_SIGNED_EN
  assign is_signed = (op == MD_MULT) || (op == MD_DIV);
`else
  assign is_signed = 1'b0;
`endif

  assign req_div = (op == MD_DIVU) || (op == MD_DIV);
  assign neg_a   = is_signed & opa[WIDTH-1];
  assign neg_b   = is_signed & opb[WIDTH-1];
  assign mag_a   = neg_a ? -opa : opa;
  assign mag_b   = neg_b ? -opb : opb;

  assign accept = (state_q == StIdle) && start && (op != MD_NONE) && !flush;
  assign last   = (cnt_q == CNT_W'(WIDTH - 1));

  assign stall       = accept || (state_q == StBusy);
  assign busy        = (state_q == StBusy);
  assign done        = (state_q == StDone);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  muldiv_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .acc_in  (acc_q),
    .operand (operand_q),
    .is_div  (is_div_q),
    .acc_out (acc_next)
  );

  // Next-state logic: flush wins over the final step, DONE always falls back to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StBusy;
      StBusy: begin
        if (flush)     state_d = StIdle;
        else if (last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sign fixup of the final step's result; divide by zero forces an all-ones quotient.
  always_comb begin
    prod = acc_next[2*WIDTH-1:0];
    quo  = acc_next[WIDTH-1:0];
    rem  = acc_next[2*WIDTH-1:WIDTH];
    if (neg_res_q) prod = -prod;
    if (neg_res_q) quo = -quo;
    if (neg_a_q)   rem = -rem;
    if (div_zero_q) quo = '1;
    hi_res = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
    lo_res = is_div_q ? quo : prod[WIDTH-1:0];
  end

  // State, iteration datapath and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      operand_q  <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_a_q    <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      dbz_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q      <= '0;
        is_div_q   <= req_div;
        neg_res_q  <= neg_a ^ neg_b;
        neg_a_q    <= neg_a;
        div_zero_q <= req_div && (opb == '0);
        dbz_q      <= 1'b0;
        // Multiply iterates over the multiplier; divide shifts the dividend out.
        acc_q      <= {{(WIDTH+1){1'b0}}, (req_div ? mag_a : mag_b)};
        operand_q  <= req_div ? mag_b : mag_a;
      end else if ((state_q == StBusy) && !flush) begin
        acc_q <= acc_next;
        cnt_q <= cnt_q + CNT_W'(1);
        if (last) begin
          hi_q  <= hi_res;
          lo_q  <= lo_res;
          dbz_q <= div_zero_q;
        end
      end
      // mthi/mtlo only outside BUSY, so they never collide with a commit.
      if (state_q != StBusy) begin
        if (hi_we) hi_q <= wdata;
        if (lo_we) lo_q <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus randomized ops against
// an arithmetic reference model.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic                   start;
  logic [MD_OP_WIDTH-1:0] op;
  logic [31:0]            opa, opb;
  logic                   hi_we, lo_we;
  logic [31:0]            wdata;
  logic                   stall, busy, done, div_by_zero;
  logic [31:0]            hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_seq #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .start       (start),
    .op          (op),
    .opa         (opa),
    .opb         (opb),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result {div_by_zero, hi, lo} from plain arithmetic.
  function automatic logic [64:0] ref_md(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    bit     sgn, is_div;
    longint sa, sb, qq, rr, pp;
    is_div = (o == MD_DIVU) || (o == MD_DIV);
`ifdef MULDIV_SIGNED_EN
    sgn = (o == MD_MULT) || (o == MD_DIV);
`else
    sgn = 1'b0;
`endif
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    if (!is_div) begin
      pp = sa * sb;
      return {1'b0, pp[63:0]};
    end
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
    qq = sa / sb;
    rr = sa % sb;
    return {1'b0, rr[31:0], qq[31:0]};
  endfunction

  // Issue one op at the current negedge, check latency and result; returns at the
  // negedge of the cycle after DONE so the next op can be back-to-back.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [64:0] exp;
    int          stall_cnt;
    int          done_cyc;
    exp = ref_md(o, a, b);
    start = 1'b1; op = o; opa = a; opb = b;
    #1;
    stall_cnt = stall ? 1 : 0;
    done_cyc  = 0;
    @(negedge clk);
    start = 1'b0; op = MD_NONE; opa = '0; opb = '0;
    check("dbz_clear_at_accept", 64'(div_by_zero), 64'd0);
    for (int cyc = 2; cyc <= 80 && done_cyc == 0; cyc++) begin
      if (stall) stall_cnt++;
      if (done) done_cyc = cyc;
      else @(negedge clk);
    end
    check("stall_cycles", 64'(stall_cnt), 64'd33);
    check("done_cycle", 64'(done_cyc), 64'd34);
    check("hi", 64'(hi), 64'(exp[63:32]));
    check("lo", 64'(lo), 64'(exp[31:0]));
    check("dbz", 64'(div_by_zero), 64'(exp[64]));
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          done_seen;
    rst = 1'b1; flush = 1'b0; start = 1'b0; op = MD_NONE; opa = '0; opb = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    check("mulu_max_lo", 64'(lo), 64'h0000_0001);

    do_op(MD_DIVU, 32'd100, 32'd7);
    check("divu_q", 64'(lo), 64'd14);
    check("divu_r", 64'(hi), 64'd2);
    do_op(MD_MULTU, 32'd3, 32'd4);
    check("b2b_lo", 64'(lo), 64'd12);

    do_op(MD_DIVU, 32'h1234, 32'd0);
    check("dz_lo", 64'(lo), 64'hFFFF_FFFF);
    check("dz_flag", 64'(div_by_zero), 64'd1);
    do_op(MD_MULTU, 32'd2, 32'd3);

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    start = 1'b1; op = MD_MULTU; opa = 32'd9; opb = 32'd9; flush = 1'b1;
    #1 check("idle_flush_stall", 64'(stall), 64'd0);
    @(negedge clk);
    check("idle_flush_busy", 64'(busy), 64'd0);
    start = 1'b0; op = MD_NONE; flush = 1'b0;

    // mthi/mtlo preload, then flush mid-operation.
    hi_we = 1'b1; wdata = 32'hAA;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hBB;
    @(negedge clk);
    lo_we = 1'b0;
    check("mthi", 64'(hi), 64'hAA);
    check("mtlo", 64'(lo), 64'hBB);
    start = 1'b1; op = MD_MULTU; opa = 32'd5; opb = 32'd5;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    repeat (9) @(negedge clk);
    check("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_after", 64'(busy), 64'd0);
    check("flush_stall_after", 64'(stall), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(done_seen), 64'd0);
    check("flush_hi", 64'(hi), 64'hAA);
    check("flush_lo", 64'(lo), 64'hBB);

    // Reset in the middle of an operation.
    start = 1'b1; op = MD_MULTU; opa = 32'd7; opb = 32'd9;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    repeat (19) @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy_after", 64'(busy), 64'd0);
    check("rst_mid_stall", 64'(stall), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_hi", 64'(hi), 64'd0);
    check("rst_mid_lo", 64'(lo), 64'd0);

    // Signed directed cases (unsigned results when the feature is off).
    do_op(MD_MULT, 32'hFFFF_FFFD, 32'd5);
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd0);

    // Randomized ops.
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(3))
        0:       ro = MD_MULTU;
        1:       ro = MD_DIVU;
        2:       ro = MD_MULT;
        default: ro = MD_DIV;
      endcase
      ra = $urandom;
      case ($urandom_range(5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(15));
        2:       rb = -32'($urandom_range(15));
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
